ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the counterpart of the PS/2 keyboard receiver already in the SoC.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic.
- Drives the open-drain PMOD clock and data lines through output-enable signals and reports the device acknowledge.
- Sits beside the receiver in the top level; the SoC bus writes bytes through a valid/ready handshake.

---
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// The host inhibits the bus, requests to send, then shifts a byte out on the
// device-generated clock. It drives the open-drain pads through output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3375,
    parameter int TIMEOUT_CYCLES = 506250
) (
    input  logic       clk,
    input  logic       reset_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;        // inhibit length, then timeout since last edge
    logic [3:0]    bit_cnt, bit_cnt_n; // device falling edges seen so far
    logic [9:0]    frame, frame_n;    // {stop, parity, data}; frame[0] is the bit on the wire
    logic          ack, ack_n;
    logic          done, done_n;
    logic          err, err_n;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          clk_s, data_s, fall;

    // Two-flop synchronizers for the pads plus one history flop for edge detect
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= '1;
            ack     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            frame   <= frame_n;
            ack     <= ack_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    // Next-state logic; the host only changes data after a detected falling edge
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        ack_n     = ack;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    frame_n   = {1'b1, ~^data_i, data_i};
                    bit_cnt_n = '0;
                    cnt_n     = '0;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n   = '0;
                    state_n = REQ;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            REQ: begin
                if (fall) begin
                    bit_cnt_n = 4'd1;
                    cnt_n     = '0;
                    state_n   = SHIFT;
                end else if (cnt == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SHIFT: begin
                if (fall) begin
                    cnt_n = '0;
                    if (bit_cnt == 4'd10) begin
                        // 11th edge: device drives data low to acknowledge
                        ack_n   = ~data_s;
                        state_n = WAIT_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        frame_n   = {1'b1, frame[9:1]};
                    end
                end else if (cnt == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_n  = ack;
                    err_n   = ~ack;
                    state_n = IDLE;
                end else if (fall) begin
                    cnt_n = '0;
                end else if (cnt == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pad enables decode from state so reset releases the bus at once
    assign ps2_clk_oe_o  = (state == INHIBIT);
    assign ps2_data_oe_o = ((state == INHIBIT) && (cnt == INH_LAST)) ||
                           (state == REQ) ||
                           ((state == SHIFT) && !frame[0]);
    assign ready_o = (state == IDLE);
    assign busy_o  = ~ready_o;
    assign done_o  = done;
    assign err_o   = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model and a
// queue of expected wire frames.
module tb_ps2_host_tx;

    localparam int INH = 10;
    localparam int TO  = 100;
    localparam int H   = 20;   // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o, busy_o, done_o, err_o;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe_o, ps2_data_oe_o;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [10:0] exp_q[$];

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe_o(ps2_clk_oe_o), .ps2_data_oe_o(ps2_data_oe_o)
    );

    // Wired-AND pads: either side may pull low
    assign ps2_clk_i  = ~(ps2_clk_oe_o | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe_o | dev_data_low);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (err_o) err_cnt <= err_cnt + 1;
        if (done_o && err_o) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wire frame as the device sees it: {stop, odd parity, data, start}
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!ready_o && w < 500) begin @(negedge clk); w++; end
        check("send_ready", 32'(ready_o), 1);
        data_i = b;
        valid_i = 1'b1;
        exp_q.push_back(model_frame(b));
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        while (!ready_o && w < 500) begin @(negedge clk); w++; end
        check(tag, 32'(ready_o), 1);
        @(negedge clk);
    endtask

    task automatic score(input string tag, input logic [10:0] got, input logic [10:0] mask);
        logic [10:0] exp;
        check({tag, "_queued"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check(tag, 32'(got & mask), 32'(exp & mask));
        end
    endtask

    // Device: waits for request-to-send, clocks n_edges falling edges and
    // samples the host data just before each rising edge.
    task automatic device_xfer(input int n_edges, input bit give_ack,
                               output logic [10:0] got, output int last_fall);
        int w = 0;
        got = '1;
        last_fall = 0;
        @(negedge clk);
        while (!(ps2_clk_i && !ps2_data_i) && w < 400) begin @(negedge clk); w++; end
        check("dev_req_seen", 32'(w < 400), 1);
        got[0] = ps2_data_i;
        repeat (H) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && give_ack) begin
                dev_data_low = 1'b1;
                repeat (H / 2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            last_fall = cyc;
            repeat (H) @(negedge clk);
            if (e <= 10) got[e] = ps2_data_i;
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    initial begin
        logic [10:0] got;
        logic [10:0] ct, dt;
        int lf, d0, e0, t0, w, busy_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_pulses", 32'({done_o, err_o}), 0);
        check("rst_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        reset_ni = 1'b1;
        repeat (2) @(negedge clk);

        // 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        device_xfer(11, 1'b1, got, lf);
        wait_idle("ed_idle");
        score("ed_frame", got, '1);
        check("ed_const", 32'(got), 32'h7DA);
        check("ed_done", done_cnt - d0, 1);
        check("ed_err", err_cnt - e0, 0);

        // 0x07 then 0x00
        d0 = done_cnt;
        send(8'h07);
        device_xfer(11, 1'b1, got, lf);
        wait_idle("b07_idle");
        score("b07_frame", got, '1);
        check("b07_parity", 32'(got[9]), 0);
        send(8'h00);
        device_xfer(11, 1'b1, got, lf);
        wait_idle("b00_idle");
        score("b00_frame", got, '1);
        check("b00_parity", 32'(got[9]), 1);
        check("b07_b00_done", done_cnt - d0, 2);

        // Inhibit timing
        data_i = 8'hA5;
        valid_i = 1'b1;
        exp_q.push_back(model_frame(8'hA5));
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            ct[i] = ps2_clk_oe_o;
            dt[i] = ps2_data_oe_o;
            if (i < 10) @(negedge clk);
        end
        check("inh_clk_oe", 32'(ct), 32'h3FF);
        check("inh_data_oe", 32'(dt), 32'h600);
        d0 = done_cnt;
        device_xfer(11, 1'b1, got, lf);
        wait_idle("a5_idle");
        score("a5_frame", got, '1);
        check("a5_done", done_cnt - d0, 1);

        // No ACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF3);
        device_xfer(11, 1'b0, got, lf);
        wait_idle("nack_idle");
        score("nack_frame", got, '1);
        check("nack_err", err_cnt - e0, 1);
        check("nack_done", done_cnt - d0, 0);
        check("nack_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 0);

        // Device never clocks
        e0 = err_cnt;
        send(8'hFF);
        w = 0;
        while (!(!ps2_clk_oe_o && ps2_data_oe_o) && w < 100) begin @(negedge clk); w++; end
        check("to_req_seen", 32'(w < 100), 1);
        t0 = cyc;
        w = 0;
        while (!err_o && w < 300) begin @(negedge clk); w++; end
        check("to_req_err_seen", 32'(err_o), 1);
        check("to_req_delay", cyc - t0, TO);
        check("to_req_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        check("to_req_ready", 32'(ready_o), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        check("to_req_err_cnt", err_cnt - e0, 1);

        // Device stops after edge 5
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF0);
        device_xfer(5, 1'b0, got, lf);
        score("stop5_frame", got, 11'h03F);
        w = 0;
        while (!err_o && w < 300) begin @(negedge clk); w++; end
        check("stop5_err_seen", 32'(err_o), 1);
        check("stop5_delay", 32'((cyc - lf >= TO) && (cyc - lf <= TO + 3)), 1);
        check("stop5_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        @(negedge clk);
        check("stop5_done", done_cnt - d0, 0);
        check("stop5_err", err_cnt - e0, 1);

        // valid_i while busy is dropped
        d0 = done_cnt;
        send(8'h3C);
        fork
            device_xfer(11, 1'b1, got, lf);
            begin
                repeat (100) @(negedge clk);
                check("busy_at_pulse", 32'(busy_o), 1);
                data_i = 8'h55;
                valid_i = 1'b1;
                @(negedge clk);
                valid_i = 1'b0;
            end
        join
        wait_idle("busy_idle");
        score("busy_frame", got, '1);
        check("busy_done", done_cnt - d0, 1);
        busy_seen = 0;
        repeat (60) begin @(negedge clk); if (busy_o || ps2_clk_oe_o) busy_seen++; end
        check("busy_no_requeue", busy_seen, 0);

        // Reset at edge 6
        d0 = done_cnt; e0 = err_cnt;
        send(8'h96);
        device_xfer(5, 1'b1, got, lf);
        score("rst_frame", got, 11'h03F);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_pre_data_oe", 32'(ps2_data_oe_o), 1);
        #2 reset_ni = 1'b0;
        #1;
        check("rst_mid_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        check("rst_mid_ready", 32'(ready_o), 1);
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_after_ready", 32'(ready_o), 1);
        check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        check("never_both", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
